// File: rtl/ws2812_pkg.sv
// Shared WS2812 constants and receiver state encoding.
// Timing values are in 27 MHz clocks and are also used by the transmitter.
package ws2812_pkg;
    localparam int WS2812_WIDTH   = 24;
    localparam int PIX_INDEX_W    = 9;

    localparam int T0H_CLK        = 11;
    localparam int T0L_CLK        = 24;
    localparam int T1H_CLK        = 23;
    localparam int T1L_CLK        = 12;
    localparam int MIN_HIGH_CLK   = 4;
    localparam int BIT_THRESH_CLK = 16;
    localparam int MAX_HIGH_CLK   = 40;
    localparam int RESET_LOW_CLK  = 1350;
    localparam int FWD_SKIP_WORDS = 1;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } ws2812_state_t;
endpackage

// File: rtl/ws2812_din_sync.sv
// 2-FF synchronizer for the raw line plus registered edge strobes.
// Strobes are aligned with the cycle in which o_level shows the new value.
module ws2812_din_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_rise, r_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_din;
            r_s2   <= r_s1;
            r_rise <= r_s1 & ~r_s2;
            r_fall <= ~r_s1 & r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 stream decoder: pulse-width bit recovery, 24-bit word assembly,
// reset-gap framing and regeneration of the stream for downstream pixels.
module ws2812_rx #(
    parameter int WS2812_WIDTH = ws2812_pkg::WS2812_WIDTH,
    parameter int MIN_HIGH     = ws2812_pkg::MIN_HIGH_CLK,
    parameter int BIT_THRESH   = ws2812_pkg::BIT_THRESH_CLK,
    parameter int MAX_HIGH     = ws2812_pkg::MAX_HIGH_CLK,
    parameter int RESET_LOW    = ws2812_pkg::RESET_LOW_CLK,
    parameter int FWD_SKIP     = ws2812_pkg::FWD_SKIP_WORDS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_din,
    output logic [WS2812_WIDTH-1:0] o_pix_data,
    output logic                    o_pix_valid,
    output logic [8:0]              o_pix_index,
    output logic                    o_frame_done,
    output logic                    o_err,
    output logic                    o_dout
);
    import ws2812_pkg::*;

    localparam int CNT_W  = $clog2(RESET_LOW + 1);
    localparam int BCNT_W = $clog2(WS2812_WIDTH + 1);

    ws2812_state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [BCNT_W-1:0]       r_bit_cnt;
    logic [WS2812_WIDTH-1:0] r_shift, r_pix_data;
    logic [8:0]              r_pix_index;
    logic                    r_pix_valid, r_frame_done, r_err, r_fwd_req, r_fwd_en;
    logic                    w_level, w_rise, w_fall;
    logic                    w_take_bit, w_err, w_frame_done, w_bit, w_word_done;

    ws2812_din_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_din   (i_din),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_bit       = (r_cnt >= CNT_W'(BIT_THRESH));
    assign w_word_done = w_take_bit && (r_bit_cnt == BCNT_W'(WS2812_WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_SYNC;
        else       r_state <= w_state_nxt;
    end

    // Every branch that could push cnt past its limit leaves the state first.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_take_bit   = 1'b0;
        w_err        = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (r_cnt == CNT_W'(RESET_LOW)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_level) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (r_cnt == CNT_W'(MAX_HIGH)) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_SYNC;
                    w_cnt_nxt   = '0;
                end else if (w_fall) begin
                    if (r_cnt < CNT_W'(MIN_HIGH)) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_SYNC;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_take_bit  = 1'b1;
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_LOW: begin
                if (r_cnt == CNT_W'(RESET_LOW)) begin
                    w_frame_done = 1'b1;
                    w_err        = (r_bit_cnt != '0);
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                end else if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_pix_data   <= '0;
            r_pix_index  <= '0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_fwd_req    <= 1'b0;
            r_fwd_en     <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_pix_valid  <= w_word_done;
            r_frame_done <= w_frame_done;
            r_err        <= w_err;
            if (w_take_bit) begin
                r_shift   <= {w_bit, r_shift[WS2812_WIDTH-1:1]};
                r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + 1'b1;
                if (w_word_done) r_pix_data <= {w_bit, r_shift[WS2812_WIDTH-1:1]};
            end
            if (r_pix_valid && r_pix_index != '1) r_pix_index <= r_pix_index + 1'b1;
            if (w_word_done && (int'(r_pix_index) + 1 >= FWD_SKIP)) r_fwd_req <= 1'b1;
            // Enable only while low so the first forwarded pulse is whole.
            if (r_fwd_req && !w_level) r_fwd_en <= 1'b1;
            if (w_state_nxt == ST_SYNC || w_state_nxt == ST_IDLE) begin
                r_bit_cnt   <= '0;
                r_pix_index <= '0;
                r_fwd_req   <= 1'b0;
                r_fwd_en    <= 1'b0;
            end
        end
    end

    assign o_pix_data   = r_pix_data;
    assign o_pix_valid  = r_pix_valid;
    assign o_pix_index  = r_pix_index;
    assign o_frame_done = r_frame_done;
    assign o_err        = r_err;
    assign o_dout       = w_level & r_fwd_en;
endmodule

// File: tb/tb_ws2812_rx.sv
// Directed + randomized bench for ws2812_rx; words are predicted from the
// driven pulse widths and events are compared with their expected cycles.
module tb_ws2812_rx;
    localparam int MINH = 4;
    localparam int TH   = 16;
    localparam int MAXH = 40;
    localparam int RL   = 1350;

    typedef struct {
        int          cyc;
        logic [23:0] data;
        logic [8:0]  idx;
    } vev_t;

    logic        clk = 1'b0;
    logic        rst, din;
    logic [23:0] pix_data;
    logic        pix_valid, frame_done, err, dout;
    logic [8:0]  pix_index;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_fall;
    bit   din_hist  [0:65535];
    logic dout_hist [0:65535];
    vev_t vq[$];
    int   eq[$];
    int   fq[$];
    int   sent_hi[$];

    ws2812_rx dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_din        (din),
        .o_pix_data   (pix_data),
        .o_pix_valid  (pix_valid),
        .o_pix_index  (pix_index),
        .o_frame_done (frame_done),
        .o_err        (err),
        .o_dout       (dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        vev_t e;
        #2;
        dout_hist[cyc] = dout;
        if (pix_valid) begin
            e.cyc = cyc; e.data = pix_data; e.idx = pix_index;
            vq.push_back(e);
        end
        if (err) eq.push_back(cyc);
        if (frame_done) fq.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            din = v;
            din_hist[cyc] = v;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pulse(input int hi, input int lo);
        sent_hi.push_back(hi);
        drive(1'b1, hi);
        last_fall = cyc;
        drive(1'b0, lo);
    endtask

    task automatic send_word(input logic [23:0] w, input bit rnd);
        int hi, lo;
        for (int k = 0; k < 24; k++) begin
            if (rnd) begin
                hi = w[k] ? int'($urandom_range(MAXH - 1, TH)) : int'($urandom_range(TH - 1, MINH));
                lo = int'($urandom_range(30, 8));
            end else begin
                hi = w[k] ? 23 : 11;
                lo = w[k] ? 12 : 24;
            end
            send_pulse(hi, lo);
        end
    endtask

    task automatic send_rand_bits(input int n);
        logic [23:0] w;
        w = 24'($urandom);
        for (int k = 0; k < n; k++)
            send_pulse(w[k] ? int'($urandom_range(MAXH - 1, TH)) : int'($urandom_range(TH - 1, MINH)),
                       int'($urandom_range(30, 8)));
    endtask

    task automatic begin_scn();
        vq.delete(); eq.delete(); fq.delete(); sent_hi.delete();
    endtask

    // Reference decode: a pulse is a 1 when its high time reaches the threshold.
    function automatic logic [23:0] model_word(input int base);
        logic [23:0] w;
        w = '0;
        for (int k = 0; k < 24; k++)
            if (sent_hi[base + k] >= TH) w[k] = 1'b1;
        return w;
    endfunction

    function automatic int dout_ones(input int a, input int b);
        int n;
        n = 0;
        for (int c = a; c < b; c++) if (dout_hist[c] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int fwd_miss(input int a, input int b);
        int n;
        n = 0;
        for (int c = a; c < b; c++) if (dout_hist[c + 2] !== logic'(din_hist[c])) n++;
        return n;
    endfunction

    initial begin
        int t0, w1s, w1e, s1, r;
        logic [23:0] rw;
        din = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_data", 32'(pix_data), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_pix_index", 32'(pix_index), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dout", 32'(dout), 0);
        rst = 1'b0;

        // single fixed word
        begin_scn(); t0 = cyc;
        drive(1'b0, 1400);
        send_word(24'h00000F, 1'b0);
        drive(1'b0, 1400);
        chk("t1_nvalid", vq.size(), 1);
        if (vq.size() > 0) begin
            chk("t1_data", 32'(vq[0].data), 32'h00000F);
            chk("t1_index", 32'(vq[0].idx), 0);
            chk("t1_valid_lat", vq[0].cyc, last_fall + 3);
        end
        chk("t1_nframe", fq.size(), 1);
        if (fq.size() > 0) chk("t1_frame_lat", fq[0], last_fall + 3 + RL);
        chk("t1_nerr", eq.size(), 0);
        chk("t1_dout_zero", dout_ones(t0, cyc), 0);

        // two fixed words, second forwarded
        begin_scn(); t0 = cyc;
        send_word(24'hA5A5A5, 1'b0);
        w1s = cyc;
        send_word(24'h123456, 1'b0);
        w1e = cyc;
        drive(1'b0, 1400);
        chk("t2_nvalid", vq.size(), 2);
        if (vq.size() > 1) begin
            chk("t2_data0", 32'(vq[0].data), 32'hA5A5A5);
            chk("t2_index0", 32'(vq[0].idx), 0);
            chk("t2_data1", 32'(vq[1].data), 32'h123456);
            chk("t2_index1", 32'(vq[1].idx), 1);
        end
        chk("t2_dout_word0", dout_ones(t0, w1s + 2), 0);
        chk("t2_fwd_word1", fwd_miss(w1s, w1e), 0);
        chk("t2_nframe", fq.size(), 1);
        chk("t2_nerr", eq.size(), 0);

        // three random words with random legal widths
        begin_scn();
        send_word(24'($urandom), 1'b1);
        s1 = cyc;
        send_word(24'($urandom), 1'b1);
        send_word(24'($urandom), 1'b1);
        w1e = cyc;
        drive(1'b0, 1400);
        chk("t2r_nvalid", vq.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (vq.size() > k) begin
                chk("t2r_data", 32'(vq[k].data), 32'(model_word(24 * k)));
                chk("t2r_index", 32'(vq[k].idx), k);
            end
        end
        chk("t2r_fwd", fwd_miss(s1, w1e), 0);

        // width boundaries: 15/16 threshold, 4 minimum, 39 maximum legal
        begin_scn();
        send_pulse(15, 20);
        send_pulse(16, 20);
        send_pulse(MINH, 20);
        send_pulse(MAXH - 1, 20);
        send_rand_bits(20);
        drive(1'b0, 1400);
        chk("t3_nvalid", vq.size(), 1);
        if (vq.size() > 0) begin
            chk("t3_data", 32'(vq[0].data), 32'(model_word(0)));
            chk("t3_thresh_bits", 32'(vq[0].data[3:0]), 32'b1010);
        end
        chk("t3_nerr", eq.size(), 0);

        // glitch mid-word, resync, then a clean word
        begin_scn();
        send_rand_bits(5);
        send_pulse(3, 20);
        t0 = last_fall;
        send_word(24'($urandom), 1'b1);
        drive(1'b0, 1360);
        send_word(24'h00FF00, 1'b0);
        drive(1'b0, 1400);
        chk("t4_nerr", eq.size(), 1);
        if (eq.size() > 0) chk("t4_err_lat", eq[0], t0 + 3);
        chk("t4_nvalid", vq.size(), 1);
        if (vq.size() > 0) begin
            chk("t4_data", 32'(vq[0].data), 32'h00FF00);
            chk("t4_index", 32'(vq[0].idx), 0);
        end
        chk("t4_nframe", fq.size(), 1);

        // over-long high
        begin_scn(); t0 = cyc; r = cyc;
        send_pulse(MAXH + 1, 20);
        drive(1'b0, 1400);
        chk("t5_nerr", eq.size(), 1);
        if (eq.size() > 0) chk("t5_err_before_fall", 32'(eq[0] < r + MAXH + 1 + 3), 1);
        chk("t5_nvalid", vq.size(), 0);
        chk("t5_nframe", fq.size(), 0);
        chk("t5_dout_zero", dout_ones(t0, cyc), 0);

        // truncated word at the reset gap
        begin_scn();
        send_rand_bits(12);
        drive(1'b0, 1400);
        chk("t5b_nframe", fq.size(), 1);
        chk("t5b_nerr", eq.size(), 1);
        if (fq.size() > 0 && eq.size() > 0) chk("t5b_same_cycle", eq[0], fq[0]);
        chk("t5b_nvalid", vq.size(), 0);

        // rst during bit 10 of the second word
        begin_scn();
        send_word(24'($urandom), 1'b1);
        send_rand_bits(9);
        drive(1'b1, 5);
        chk("t6_dout_fwd", 32'(dout), 1);
        chk("t6_index_pre", 32'(pix_index), 1);
        rst = 1'b1;
        drive(1'b1, 1);
        chk("t6_rst_pix_data", 32'(pix_data), 0);
        chk("t6_rst_pix_valid", 32'(pix_valid), 0);
        chk("t6_rst_pix_index", 32'(pix_index), 0);
        chk("t6_rst_frame_done", 32'(frame_done), 0);
        chk("t6_rst_err", 32'(err), 0);
        chk("t6_rst_dout", 32'(dout), 0);
        rst = 1'b0;
        drive(1'b1, 17);
        drive(1'b0, 12);
        vq.delete();
        send_rand_bits(14);
        drive(1'b0, 1360);
        chk("t6_nvalid_after_rst", vq.size(), 0);
        sent_hi.delete();
        rw = 24'($urandom);
        send_word(rw, 1'b1);
        drive(1'b0, 1400);
        chk("t6_nvalid_resync", vq.size(), 1);
        if (vq.size() > 0) begin
            chk("t6_data", 32'(vq[0].data), 32'(model_word(0)));
            chk("t6_index", 32'(vq[0].idx), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
